// File: rtl/icache_refill_unit_if.sv
// rtl/icache_refill_unit_if.sv - refill unit bus bundle: miss/redirect in, memory burst, array writes, resume out
// Ports (master = refill unit, slave = tag stage / memory / arrays):
//   miss_valid, miss_pc                       tag-stage miss report
//   wb_do_branch, wb_branch_target,
//   wb_icache_invalidate                      writeback redirect / invalidate
//   mem_req_valid/ready/addr, mem_rsp_valid/data   line read request and in-order response words
//   data_wr_*                                 data array write port
//   tag_wr_*                                  tag array write port
//   resume_fetch, resume_pc, busy             fetch restart and status
interface icache_refill_unit_if #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
);
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic              miss_valid;
  logic [ADDR_W-1:0] miss_pc;
  logic              wb_do_branch;
  logic [ADDR_W-1:0] wb_branch_target;
  logic              wb_icache_invalidate;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              data_wr_en;
  logic [SET_W-1:0]  data_wr_set;
  logic [WAY_W-1:0]  data_wr_way;
  logic [WORD_W-1:0] data_wr_word;
  logic [31:0]       data_wr_data;
  logic              tag_wr_en;
  logic [SET_W-1:0]  tag_wr_set;
  logic [NUM_WAYS-1:0] tag_wr_way_mask;
  logic [TAG_W-1:0]  tag_wr_tag;
  logic              tag_wr_valid;
  logic              resume_fetch;
  logic [ADDR_W-1:0] resume_pc;
  logic              busy;

  modport master (
    input  miss_valid, miss_pc, wb_do_branch, wb_branch_target, wb_icache_invalidate,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output mem_req_valid, mem_req_addr,
    output data_wr_en, data_wr_set, data_wr_way, data_wr_word, data_wr_data,
    output tag_wr_en, tag_wr_set, tag_wr_way_mask, tag_wr_tag, tag_wr_valid,
    output resume_fetch, resume_pc, busy
  );

  modport slave (
    output miss_valid, miss_pc, wb_do_branch, wb_branch_target, wb_icache_invalidate,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  mem_req_valid, mem_req_addr,
    input  data_wr_en, data_wr_set, data_wr_way, data_wr_word, data_wr_data,
    input  tag_wr_en, tag_wr_set, tag_wr_way_mask, tag_wr_tag, tag_wr_valid,
    input  resume_fetch, resume_pc, busy
  );
endinterface

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - I-cache miss/refill controller with invalidate sweep and fetch resume
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    icache_refill_unit_if.master (miss/redirect in, memory request/response,
//          data/tag array write ports, resume_fetch/resume_pc/busy)
module icache_refill_unit #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic i_clk,
  input  logic i_rst,
  icache_refill_unit_if.master bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {S_SWEEP, S_IDLE, S_REQ, S_FILL, S_RESUME} state_t;

  state_t              r_state;
  logic [SET_W-1:0]    r_set_ctr;
  logic [WORD_W-1:0]   r_word_ctr;
  logic [WAY_W-1:0]    r_victim;
  logic [WAY_W-1:0]    r_way;
  logic [SET_W-1:0]    r_set;
  logic [TAG_W-1:0]    r_tag;
  logic [ADDR_W-1:0]   r_target;
  logic                r_pend_inv;
  // Redirect seen in RESUME, replayed by IDLE on the following cycle.
  logic                r_pend_br;
  logic                r_pend_br_inv;

  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_mem_req_addr;
  logic                r_data_wr_en;
  logic [SET_W-1:0]    r_data_wr_set;
  logic [WAY_W-1:0]    r_data_wr_way;
  logic [WORD_W-1:0]   r_data_wr_word;
  logic [31:0]         r_data_wr_data;
  logic                r_tag_wr_en;
  logic [SET_W-1:0]    r_tag_wr_set;
  logic [NUM_WAYS-1:0] r_tag_wr_way_mask;
  logic [TAG_W-1:0]    r_tag_wr_tag;
  logic                r_tag_wr_valid;
  logic                r_resume_fetch;
  logic [ADDR_W-1:0]   r_resume_pc;

  logic                w_redirect;
  logic                w_inv;
  logic                w_idle_br;
  logic                w_idle_inv;
  logic [WAY_W-1:0]    w_victim_next;
  logic                w_last_word;

  assign w_redirect    = bus.wb_do_branch;
  assign w_inv         = bus.wb_do_branch & bus.wb_icache_invalidate;
  assign w_idle_br     = w_redirect | r_pend_br;
  assign w_idle_inv    = w_redirect ? w_inv : (r_pend_br & r_pend_br_inv);
  assign w_victim_next = (NUM_WAYS == 1) ? '0 : WAY_W'(r_victim + 1'b1);
  assign w_last_word   = (r_word_ctr == WORD_W'(LINE_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= S_SWEEP;
      r_set_ctr         <= '0;
      r_word_ctr        <= '0;
      r_victim          <= '0;
      r_way             <= '0;
      r_set             <= '0;
      r_tag             <= '0;
      r_target          <= RESET_PC;
      r_pend_inv        <= 1'b0;
      r_pend_br         <= 1'b0;
      r_pend_br_inv     <= 1'b0;
      r_mem_req_valid   <= 1'b0;
      r_mem_req_addr    <= '0;
      r_data_wr_en      <= 1'b0;
      r_data_wr_set     <= '0;
      r_data_wr_way     <= '0;
      r_data_wr_word    <= '0;
      r_data_wr_data    <= '0;
      r_tag_wr_en       <= 1'b0;
      r_tag_wr_set      <= '0;
      r_tag_wr_way_mask <= '0;
      r_tag_wr_tag      <= '0;
      r_tag_wr_valid    <= 1'b0;
      r_resume_fetch    <= 1'b0;
      r_resume_pc       <= '0;
    end else begin
      r_data_wr_en   <= 1'b0;
      r_tag_wr_en    <= 1'b0;
      r_resume_fetch <= 1'b0;

      case (r_state)
        S_SWEEP: begin
          r_tag_wr_en       <= 1'b1;
          r_tag_wr_set      <= r_set_ctr;
          r_tag_wr_way_mask <= '1;
          r_tag_wr_tag      <= '0;
          r_tag_wr_valid    <= 1'b0;
          if (w_redirect) r_target <= bus.wb_branch_target;
          // A fresh invalidate restarts the sweep so every set is cleared after it.
          if (w_inv) begin
            r_set_ctr <= '0;
          end else if (r_set_ctr == SET_W'(NUM_SETS - 1)) begin
            r_set_ctr <= '0;
            r_state   <= S_RESUME;
          end else begin
            r_set_ctr <= r_set_ctr + 1'b1;
          end
        end

        S_IDLE: begin
          r_pend_br     <= 1'b0;
          r_pend_br_inv <= 1'b0;
          if (w_redirect) r_target <= bus.wb_branch_target;
          if (w_idle_br && w_idle_inv) begin
            r_pend_inv <= 1'b0;
            r_set_ctr  <= '0;
            r_state    <= S_SWEEP;
          end else if (w_idle_br) begin
            // Miss belongs to the wrong path; drop it.
            r_state <= S_IDLE;
          end else if (bus.miss_valid) begin
            r_set           <= bus.miss_pc[OFF_W +: SET_W];
            r_tag           <= bus.miss_pc[ADDR_W-1 -: TAG_W];
            r_way           <= r_victim;
            r_target        <= bus.miss_pc;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {bus.miss_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_state         <= S_REQ;
          end
        end

        S_REQ: begin
          if (w_redirect) r_target <= bus.wb_branch_target;
          if (w_inv) r_pend_inv <= 1'b1;
          // mem_req_valid is already high in this state, so ready completes the handshake.
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_word_ctr      <= '0;
            r_state         <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_redirect) r_target <= bus.wb_branch_target;
          if (w_inv) r_pend_inv <= 1'b1;
          if (bus.mem_rsp_valid) begin
            r_data_wr_en   <= 1'b1;
            r_data_wr_set  <= r_set;
            r_data_wr_way  <= r_way;
            r_data_wr_word <= r_word_ctr;
            r_data_wr_data <= bus.mem_rsp_data;
            r_word_ctr     <= r_word_ctr + 1'b1;
            if (w_last_word) begin
              r_tag_wr_en       <= 1'b1;
              r_tag_wr_set      <= r_set;
              r_tag_wr_way_mask <= NUM_WAYS'(1) << r_way;
              r_tag_wr_tag      <= r_tag;
              r_tag_wr_valid    <= 1'b1;
              r_victim          <= w_victim_next;
              // Invalidate seen during the refill sweeps first, wiping the line just filled.
              if (r_pend_inv || w_inv) begin
                r_pend_inv <= 1'b0;
                r_set_ctr  <= '0;
                r_state    <= S_SWEEP;
              end else begin
                r_state <= S_RESUME;
              end
            end
          end
        end

        S_RESUME: begin
          r_resume_fetch <= 1'b1;
          r_resume_pc    <= r_target;
          r_state        <= S_IDLE;
          if (w_redirect) begin
            r_target      <= bus.wb_branch_target;
            r_pend_br     <= 1'b1;
            r_pend_br_inv <= w_inv;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid   = r_mem_req_valid;
  assign bus.mem_req_addr    = r_mem_req_addr;
  assign bus.data_wr_en      = r_data_wr_en;
  assign bus.data_wr_set     = r_data_wr_set;
  assign bus.data_wr_way     = r_data_wr_way;
  assign bus.data_wr_word    = r_data_wr_word;
  assign bus.data_wr_data    = r_data_wr_data;
  assign bus.tag_wr_en       = r_tag_wr_en;
  assign bus.tag_wr_set      = r_tag_wr_set;
  assign bus.tag_wr_way_mask = r_tag_wr_way_mask;
  assign bus.tag_wr_tag      = r_tag_wr_tag;
  assign bus.tag_wr_valid    = r_tag_wr_valid;
  assign bus.resume_fetch    = r_resume_fetch;
  assign bus.resume_pc       = r_resume_pc;
  assign bus.busy            = (r_state != S_IDLE);
endmodule
